// File: rtl/echo_effect_pkg.sv
// Shared definitions for the echo effect: FSM state encoding and
// saturation limits for a signed sample of a given width.
package echo_effect_pkg;

  typedef enum logic [2:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_REQ,
    ST_CAPTURE,
    ST_CALC,
    ST_OUT,
    ST_WAIT_DONE
  } state_t;

  function automatic longint sat_max(input int width);
    return (longint'(1) <<< (width - 1)) - 1;
  endfunction

  function automatic longint sat_min(input int width);
    return -(longint'(1) <<< (width - 1));
  endfunction

endpackage

// File: rtl/echo_effect_delay_ram.sv
// Simple dual-port delay line: one write port, one registered read port.
module delay_ram #(
  parameter int d_width = 16,
  parameter int depth   = 4096,
  parameter int addr_w  = $clog2(depth)
) (
  input  logic               clk,
  input  logic               we,
  input  logic [addr_w-1:0]  waddr,
  input  logic [d_width-1:0] wdata,
  input  logic [addr_w-1:0]  raddr,
  output logic [d_width-1:0] rdata
);

  logic [d_width-1:0] mem [depth];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/echo_effect.sv
// Feedback echo: y = sat(x + (y[n-delay_depth] >>> decay_shift)), one sample
// per upstream pop / downstream acknowledge handshake.
module echo_effect
  import echo_effect_pkg::*;
#(
  parameter int d_width     = 16,
  parameter int delay_depth = 4096,
  parameter int decay_shift = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_enable,
  input  logic                      i_data_ready,
  input  logic signed [d_width-1:0] i_data,
  input  logic                      i_read_done,
  output logic                      o_read_enable,
  output logic                      o_data_valid,
  output logic signed [d_width-1:0] o_data,
  output logic                      o_busy
);

  localparam int addr_w = $clog2(delay_depth);
  localparam logic [addr_w-1:0] last_addr = addr_w'(delay_depth - 1);
  localparam logic signed [d_width:0] sum_max = (d_width + 1)'(sat_max(d_width));
  localparam logic signed [d_width:0] sum_min = (d_width + 1)'(sat_min(d_width));

  state_t state_reg;
  logic [addr_w-1:0] clr_ptr_reg;
  logic [addr_w-1:0] wr_ptr_reg;
  logic signed [d_width-1:0] x_reg;
  logic signed [d_width-1:0] d_reg;

  logic signed [d_width-1:0] d_shifted;
  logic signed [d_width:0]   sum_next;
  logic signed [d_width-1:0] y_next;

  logic                      ram_we;
  logic [addr_w-1:0]         ram_waddr;
  logic [d_width-1:0]        ram_wdata;
  logic [d_width-1:0]        ram_rdata;

  always_comb begin
    d_shifted = d_reg >>> decay_shift;
    sum_next  = {x_reg[d_width-1], x_reg} + {d_shifted[d_width-1], d_shifted};
    y_next    = x_reg;
    if (i_enable) begin
      if (sum_next > sum_max) begin
        y_next = sum_max[d_width-1:0];
      end else if (sum_next < sum_min) begin
        y_next = sum_min[d_width-1:0];
      end else begin
        y_next = sum_next[d_width-1:0];
      end
    end
  end

  // The read port always follows wr_ptr, so the slot about to be overwritten
  // is already on rdata by the time the FSM reaches CAPTURE.
  always_comb begin
    ram_we    = (state_reg == ST_CLEAR) || (state_reg == ST_CALC);
    ram_waddr = (state_reg == ST_CLEAR) ? clr_ptr_reg : wr_ptr_reg;
    ram_wdata = (state_reg == ST_CLEAR) ? '0 : y_next;
  end

  delay_ram #(
    .d_width (d_width),
    .depth   (delay_depth),
    .addr_w  (addr_w)
  ) u_delay_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (wr_ptr_reg),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_CLEAR;
      clr_ptr_reg   <= '0;
      wr_ptr_reg    <= '0;
      x_reg         <= '0;
      d_reg         <= '0;
      o_read_enable <= 1'b0;
      o_data_valid  <= 1'b0;
      o_data        <= '0;
      o_busy        <= 1'b1;
    end else begin
      o_read_enable <= 1'b0;
      o_data_valid  <= 1'b0;
      case (state_reg)
        ST_CLEAR: begin
          clr_ptr_reg <= clr_ptr_reg + addr_w'(1);
          if (clr_ptr_reg == last_addr) begin
            state_reg <= ST_IDLE;
            o_busy    <= 1'b0;
          end
        end
        ST_IDLE: begin
          if (i_data_ready) begin
            state_reg     <= ST_REQ;
            o_read_enable <= 1'b1;
          end
        end
        ST_REQ: begin
          state_reg <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          x_reg     <= i_data;
          d_reg     <= ram_rdata;
          state_reg <= ST_CALC;
        end
        ST_CALC: begin
          o_data       <= y_next;
          o_data_valid <= 1'b1;
          wr_ptr_reg   <= wr_ptr_reg + addr_w'(1);
          state_reg    <= ST_OUT;
        end
        ST_OUT: begin
          state_reg <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          if (i_read_done) begin
            state_reg <= ST_IDLE;
          end
        end
        default: begin
          state_reg   <= ST_CLEAR;
          clr_ptr_reg <= '0;
          o_busy      <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_echo_effect.sv
// Self-checking bench for echo_effect at depth 8, shift 1: vector tables,
// hand-written handshake/reset sequences and a randomized model comparison.
module tb_echo_effect;

  localparam int DW    = 16;
  localparam int DEPTH = 8;
  localparam int SHIFT = 1;

  logic clk = 1'b0;
  logic reset;
  logic i_enable;
  logic i_data_ready;
  logic signed [DW-1:0] i_data;
  logic i_read_done;
  logic o_read_enable;
  logic o_data_valid;
  logic signed [DW-1:0] o_data;
  logic o_busy;

  always #20 clk = ~clk;

  echo_effect #(
    .d_width     (DW),
    .delay_depth (DEPTH),
    .decay_shift (SHIFT)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .i_enable      (i_enable),
    .i_data_ready  (i_data_ready),
    .i_data        (i_data),
    .i_read_done   (i_read_done),
    .o_read_enable (o_read_enable),
    .o_data_valid  (o_data_valid),
    .o_data        (o_data),
    .o_busy        (o_busy)
  );

  int checks = 0;
  int errors = 0;
  int hist[$];

  typedef struct {
    bit rst;
    int x;
    bit en;
    int exp_y;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic int clamp(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // Reference: output history since the last clear; echo taps DEPTH outputs back.
  function automatic int model_step(input int x, input bit en);
    int d;
    int y;
    d = (hist.size() >= DEPTH) ? hist[hist.size() - DEPTH] : 0;
    y = en ? clamp(x + (d >>> SHIFT)) : x;
    hist.push_back(y);
    return y;
  endfunction

  function automatic void add_vec(input bit rst, input int x, input bit en, input int exp_y);
    vec_t v;
    v.rst = rst; v.x = x; v.en = en; v.exp_y = exp_y;
    vecs.push_back(v);
  endfunction

  task automatic do_reset();
    int n;
    reset = 1'b1;
    i_data_ready = 1'b0;
    i_read_done = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", int'(o_busy), 1);
    check("rst_read_enable", int'(o_read_enable), 0);
    check("rst_valid", int'(o_data_valid), 0);
    check("rst_data", int'(o_data), 0);
    reset = 1'b0;
    n = 0;
    while (o_busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("clear_done", int'(o_busy), 0);
    hist.delete();
  endtask

  task automatic run_sample(input int x, input bit en, input int exp_y, input int done_dly);
    int n;
    int bad;
    i_data = DW'(x);
    i_enable = en;
    i_data_ready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!o_read_enable && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("read_enable_seen", int'(o_read_enable), 1);
    if (!o_read_enable) begin
      i_data_ready = 1'b0;
      return;
    end
    i_data_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("valid_latency", int'(o_data_valid), 1);
    check("sample_out", int'(o_data), exp_y);
    $display("sample x=%0d en=%0d y=%0d expect=%0d", x, en, int'(o_data), exp_y);
    bad = 0;
    @(negedge clk);
    for (int d = 0; d < done_dly; d++) begin
      if (o_data_valid || o_read_enable || int'(o_data) != exp_y) bad++;
      @(negedge clk);
    end
    check("wait_hold", bad, 0);
    i_read_done = 1'b1;
    @(negedge clk);
    i_read_done = 1'b0;
  endtask

  initial begin
    int busy_cnt;
    int re_cnt;
    int vld_cnt;
    int bad;
    int n;
    int x;
    bit en;
    int y;
    int bypass_vals[8];

    reset = 1'b1;
    i_enable = 1'b1;
    i_data_ready = 1'b1;
    i_data = '0;
    i_read_done = 1'b0;

    // Reset / clear sequence with upstream claiming data the whole time.
    repeat (3) @(negedge clk);
    check("init_busy", int'(o_busy), 1);
    check("init_data", int'(o_data), 0);
    reset = 1'b0;
    busy_cnt = 0;
    re_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (o_busy) busy_cnt++;
      if (o_read_enable) re_cnt++;
      if (!o_busy) i_data_ready = 1'b0;
      @(negedge clk);
    end
    check("clear_busy_cycles", busy_cnt, DEPTH);
    check("clear_no_read", re_cnt, 0);
    $display("clear busy_cycles=%0d reads=%0d", busy_cnt, re_cnt);

    // Vector table: impulse, saturation (+/-), bypass then echo of bypassed data.
    add_vec(1, 16384, 1, 16384);
    for (int i = 1; i < 16; i++) add_vec(0, 0, 1, (i == 8) ? 8192 : 0);
    for (int i = 0; i < 9; i++) add_vec(i == 0, 30000, 1, (i == 8) ? 32767 : 30000);
    for (int i = 0; i < 9; i++) add_vec(i == 0, -30000, 1, (i == 8) ? -32768 : -30000);
    bypass_vals = '{100, -200, 32767, -32768, 7, -7, 1, -1};
    for (int i = 0; i < 8; i++) add_vec(i == 0, bypass_vals[i], 0, bypass_vals[i]);
    add_vec(0, 0, 1, 50);
    add_vec(0, 0, 1, -100);
    add_vec(0, 0, 1, 16383);
    add_vec(0, 0, 1, -16384);
    add_vec(0, 0, 1, 3);
    add_vec(0, 0, 1, -4);
    add_vec(0, 0, 1, 0);
    add_vec(0, 0, 1, -1);
    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset();
      run_sample(vecs[i].x, vecs[i].en, vecs[i].exp_y, 0);
    end

    // Randomized traffic against the reference model.
    do_reset();
    for (int i = 0; i < 40; i++) begin
      x = int'($urandom_range(0, 65535)) - 32768;
      en = ($urandom_range(0, 3) != 0);
      y = model_step(x, en);
      run_sample(x, en, y, int'($urandom_range(0, 3)));
    end

    // Handshake: data_ready held high, acknowledge delayed 20 cycles.
    i_enable = 1'b1;
    i_data_ready = 1'b1;
    for (int s = 0; s < 3; s++) begin
      x = 1000 * (s + 1);
      i_data = DW'(x);
      y = model_step(x, 1'b1);
      re_cnt = 0;
      n = 0;
      @(negedge clk);
      while (!o_data_valid && n < 30) begin
        if (o_read_enable) re_cnt++;
        @(negedge clk);
        n++;
      end
      check("hs_valid", int'(o_data_valid), 1);
      check("hs_data", int'(o_data), y);
      bad = 0;
      for (int d = 0; d < 20; d++) begin
        @(negedge clk);
        if (o_read_enable) re_cnt++;
        if (o_data_valid || int'(o_data) != y) bad++;
      end
      check("hs_one_read", re_cnt, 1);
      check("hs_hold", bad, 0);
      $display("handshake s=%0d y=%0d reads=%0d", s, int'(o_data), re_cnt);
      i_read_done = 1'b1;
      @(negedge clk);
      i_read_done = 1'b0;
    end
    i_data_ready = 1'b0;

    // Reset asserted while the FSM is in CALC.
    do_reset();
    run_sample(777, 1'b1, model_step(777, 1'b1), 1);
    i_data = DW'(1234);
    i_enable = 1'b1;
    i_data_ready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!o_read_enable && n < 50) begin
      @(negedge clk);
      n++;
    end
    i_data_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("calc_rst_busy", int'(o_busy), 1);
    check("calc_rst_valid", int'(o_data_valid), 0);
    check("calc_rst_wr_ptr", int'(dut.wr_ptr_reg), 0);
    reset = 1'b0;
    vld_cnt = 0;
    re_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (o_data_valid) vld_cnt++;
      if (o_read_enable) re_cnt++;
      @(negedge clk);
    end
    check("calc_rst_no_valid", vld_cnt, 0);
    check("calc_rst_no_read", re_cnt, 0);
    check("calc_rst_idle", int'(o_busy), 0);
    $display("calc reset valids=%0d reads=%0d", vld_cnt, re_cnt);
    hist.delete();
    for (int i = 0; i < 9; i++) begin
      x = (i == 0) ? 2000 : 0;
      run_sample(x, 1'b1, model_step(x, 1'b1), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
